bus_mux_arb: RTL and testbench
==============================

// Module: bus_mux_arb
// PURPOSE
//  Parametrised N-input, WIDTH-bit registered bus multiplexer with valid/ready handshake.
//  Successor to the 2:1 combinational nibble mux; it sits between the datapath sources
//  (ALU, register file, immediate, memory read) and a shared destination bus.
//  Two modes: explicit select, or round-robin arbitration.
//  Multi-beat transfers lock the grant until the last beat.
// PARAMETERS
//  WIDTH   8               data width per channel
//  N       4               number of input channels (>=2; need not be a power of two)
//  SEL_W   $clog2(N)       width of sel and out_src
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  mode       in   1          0 = SELECT (use sel), 1 = ROUND_ROBIN
//  sel        in   SEL_W      channel index in SELECT mode
//  in_data    in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N          per-channel valid
//  in_last    in   N          per-channel last-beat flag (1 = single/final beat)
//  in_ready   out  N          per-channel ready (combinational)
//  out_data   out  WIDTH      registered output data
//  out_src    out  SEL_W      index of the channel that supplied out_data
//  out_last   out  1          registered copy of the accepted in_last
//  out_valid  out  1          output holds a beat
//  out_ready  in   1          downstream accepts
// BEHAVIOUR
//  - Reset (async, any cycle): out_valid=0, out_data=0, out_src=0, out_last=0,
//    rr_ptr=0, state=ARB. A beat in flight is discarded.
//  - space = !out_valid | out_ready. load = space & gnt_vld & in_valid[gnt].
//  - in_ready[gnt] = space & gnt_vld; all other in_ready bits are 0.
//  - On load: out_data<=in_data[gnt], out_src<=gnt, out_last<=in_last[gnt], out_valid<=1.
//    Otherwise, if out_ready, out_valid<=0 and data regs hold.
//  - Latency is 1 clk from input accept to out_valid. Throughput is 1 beat/clk.
//  - Output stable: while out_valid & !out_ready, out_* must not change.
//  - Grant selection, state ARB:
//      SELECT: gnt=sel. gnt_vld = (sel<N) & in_valid[sel]. sel>=N gives no grant.
//      ROUND_ROBIN: gnt = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
//                   gnt_vld = |in_valid.
//  - FSM, 2 states:
//      ARB    -> LOCKED  on load & !in_last[gnt]; latch lock_ch=gnt.
//      LOCKED: gnt=lock_ch, gnt_vld=in_valid[lock_ch]. mode and sel are ignored.
//      LOCKED -> ARB     on load & in_last[lock_ch].
//  - rr_ptr update: on a load whose beat has in_last=1, rr_ptr <= (gnt+1) mod N, with
//    wrap at N, not 2^SEL_W. rr_ptr is updated in both modes.
//  - Changes to mode or sel take effect in the next ARB evaluation. They never disturb a
//    held output or a locked packet.
//  - Simultaneous drain and load in one clk: the new beat replaces the old, out_valid
//    stays 1, and there is no bubble.
// STRUCTURE
//  - Shared package risc_bus_pkg: MODE_SELECT=1'b0, MODE_RR=1'b1,
//    state encoding ST_ARB=1'b0, ST_LOCKED=1'b1.
//  - One sub-module, rr_pick #(N): rotating-priority encoder.
//    Inputs req[N] and ptr; outputs gnt[SEL_W] and gnt_vld.
//  - Top level contains the FSM, rr_ptr, lock_ch, the output register and ready decode.
// TESTING
//  1. rst=1 mid-transfer (out_valid=1) -> same cycle out_valid=0, out_data=0;
//     after release, rr_ptr=0.
//  2. SELECT, sel=2, in_data[ch2]=8'hA5, all valid, last=1, out_ready=1
//     -> in_ready=4'b0100; next clk out_data=A5, out_src=2.
//  3. RR, in_valid=4'b1111, last=1, out_ready=1
//     -> out_src sequence 0,1,2,3,0 on consecutive clks;
//     with in_valid=4'b1001 -> 0,3,0,3.
//  4. Backpressure: out_ready=0 for 3 clks with out_valid=1
//     -> out_data/out_src frozen, in_ready=0.
//     Then out_ready=1 -> next beat loads with no bubble.
//  5. Lock: RR, ch1 sends 3 beats (last on 3rd) while ch2 is valid; mode toggled mid-packet
//     -> out_src=1,1,1 then 2; sel/mode ignored during the lock.
//  6. N=3, SELECT, sel=3 -> in_ready=0, out_valid stays 0.
//     RR wrap with N=3 -> out_src 0,1,2,0.

Source files
------------

// File: rtl/risc_bus_pkg.sv
// Shared bus encodings: operating modes and the arbiter/lock FSM states.
package risc_bus_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/bus_mux_arb_rr_pick.sv
// Rotating-priority encoder: first asserted req at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt,
    output logic             gnt_vld
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            for (int i = 0; i < N; i++) begin
                if (i == idx && req[i] && !gnt_vld) begin
                    gnt     = SEL_W'(i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_mux_arb.sv
// N-input registered bus mux with valid/ready handshake, explicit-select or
// round-robin arbitration, and grant locking across multi-beat packets.
module bus_mux_arb
    import risc_bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_src,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, lock_ch;
    logic [SEL_W-1:0]   rr_gnt, gnt;
    logic               rr_vld, gnt_vld;
    logic               sel_vld, lock_vld;
    logic [WIDTH-1:0]   gnt_data;
    logic               gnt_last, gnt_in_valid;
    logic               space, load;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // A sel value of N or more matches no channel and therefore never grants.
    always_comb begin
        sel_vld  = 1'b0;
        lock_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i))     sel_vld  = in_valid[i];
            if (lock_ch == SEL_W'(i)) lock_vld = in_valid[i];
        end
    end

    always_comb begin
        if (state == ST_LOCKED) begin
            gnt     = lock_ch;
            gnt_vld = lock_vld;
        end else if (mode == MODE_SELECT) begin
            gnt     = sel;
            gnt_vld = sel_vld;
        end else begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end
    end

    always_comb begin
        gnt_data     = '0;
        gnt_last     = 1'b0;
        gnt_in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data     = in_data[i*WIDTH +: WIDTH];
                gnt_last     = in_last[i];
                gnt_in_valid = in_valid[i];
            end
        end
    end

    assign space = !out_valid || out_ready;
    assign load  = space && gnt_vld && gnt_in_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = space && gnt_vld && (gnt == SEL_W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:    if (load && !gnt_last) state_nxt = ST_LOCKED;
            ST_LOCKED: if (load && gnt_last)  state_nxt = ST_ARB;
            default:   state_nxt = ST_ARB;
        endcase
    end

    // NOTE: clocked state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ARB;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else begin
            if (load && gnt_last)
                rr_ptr <= (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;
            if (state == ST_ARB && load && !gnt_last)
                lock_ch <= gnt;
        end
    end

    // A load and a drain in the same cycle overwrite the held beat with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt;
            out_last  <= gnt_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: a vector table for arbitration plus hand
// sequences for backpressure, packet locking, reset and an N=3 instance.
module tb_bus_mux_arb;
    import risc_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        mode, out_ready;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_last, out_valid;

    logic        mode3, out_ready3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_last3, in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_src3;
    logic        out_last3, out_valid3;

    logic [7:0]  chan_data  [4];
    logic [7:0]  chan_data3 [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_mux_arb #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    bus_mux_arb #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
        .out_data(out_data3), .out_src(out_src3), .out_last(out_last3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_src;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic [3:0] l, input logic r);
        mode = m; sel = s; in_valid = v; in_last = l; out_ready = r;
    endtask

    task automatic expect_beat(input string name, input logic [1:0] src, input logic last);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " src"},   32'(out_src),   32'(src));
        check({name, " data"},  32'(out_data),  32'(chan_data[src]));
        check({name, " last"},  32'(out_last),  32'(last));
    endtask

    initial begin
        chan_data[0] = 8'h11; chan_data[1] = 8'h22; chan_data[2] = 8'hA5; chan_data[3] = 8'h33;
        chan_data3[0] = 8'h31; chan_data3[1] = 8'h32; chan_data3[2] = 8'h33;
        in_data  = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
        in_data3 = {chan_data3[2], chan_data3[1], chan_data3[0]};
        mode3 = MODE_SELECT; sel3 = 2'd0; in_valid3 = '0; in_last3 = '1; out_ready3 = 1'b1;

        // RR from ptr 0: 0,1,2,3; then valid 1001 gives 0,3,0,3; then select and idle cases.
        vecs[0]  = '{MODE_RR,     2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{MODE_RR,     2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{MODE_RR,     2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{MODE_RR,     2'd0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{MODE_RR,     2'd0, 4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{MODE_RR,     2'd0, 4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[6]  = '{MODE_RR,     2'd0, 4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[7]  = '{MODE_RR,     2'd0, 4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{MODE_SELECT, 2'd2, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[9]  = '{MODE_SELECT, 2'd1, 4'b0101, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[10] = '{MODE_RR,     2'd0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[11] = '{MODE_RR,     2'd0, 4'b0110, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};

        rst = 1'b1;
        drive(MODE_SELECT, 2'd0, 4'b0000, 4'b1111, 1'b1);
        #2;
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset data",  32'(out_data),  32'd0);
        check("reset src",   32'(out_src),   32'd0);
        check("reset last",  32'(out_last),  32'd0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].last, vecs[i].ordy);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            step();
            if (vecs[i].exp_ov)
                expect_beat($sformatf("v%0d", i), vecs[i].exp_src, 1'b1);
            else
                check($sformatf("v%0d valid", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: held beat from ch1, rr_ptr=2.
        drive(MODE_RR, 2'd0, 4'b1111, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            step();
            expect_beat($sformatf("bp%0d", c), 2'd1, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'b0100);
        step();
        expect_beat("bp release", 2'd2, 1'b1);

        // Lock: rr_ptr=3, ch1 and ch2 valid, ch1 packet of 3 beats.
        drive(MODE_RR, 2'd0, 4'b0110, 4'b0000, 1'b1);
        #1;
        check("lock b0 in_ready", 32'(in_ready), 32'b0010);
        step();
        expect_beat("lock b0", 2'd1, 1'b0);
        drive(MODE_SELECT, 2'd2, 4'b0110, 4'b0000, 1'b1);
        #1;
        check("lock b1 in_ready", 32'(in_ready), 32'b0010);
        step();
        expect_beat("lock b1", 2'd1, 1'b0);
        drive(MODE_RR, 2'd0, 4'b0110, 4'b0010, 1'b1);
        #1;
        check("lock b2 in_ready", 32'(in_ready), 32'b0010);
        step();
        expect_beat("lock b2", 2'd1, 1'b1);
        drive(MODE_RR, 2'd0, 4'b0110, 4'b1111, 1'b1);
        #1;
        check("unlock in_ready", 32'(in_ready), 32'b0100);
        step();
        expect_beat("unlock", 2'd2, 1'b1);

        // Reset with a beat held under backpressure.
        drive(MODE_RR, 2'd0, 4'b0000, 4'b1111, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst valid", 32'(out_valid), 32'd0);
        check("midrst data",  32'(out_data),  32'd0);
        step();
        rst = 1'b0;
        drive(MODE_RR, 2'd0, 4'b1111, 4'b1111, 1'b1);
        #1;
        check("post-rst rr_ptr", 32'(in_ready), 32'b0001);
        step();
        expect_beat("post-rst", 2'd0, 1'b1);
        drive(MODE_RR, 2'd0, 4'b0000, 4'b1111, 1'b1);

        // N=3: out-of-range select, then RR wrap at 3.
        mode3 = MODE_SELECT; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        check("n3 sel3 in_ready", 32'(in_ready3), 32'd0);
        step();
        check("n3 sel3 valid", 32'(out_valid3), 32'd0);
        mode3 = MODE_RR;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] e;
            e = 2'(k % 3);
            #1;
            check($sformatf("n3 rr%0d in_ready", k), 32'(in_ready3), 32'(3'b001 << e));
            step();
            check($sformatf("n3 rr%0d valid", k), 32'(out_valid3), 32'd1);
            check($sformatf("n3 rr%0d src", k),   32'(out_src3),   32'(e));
            check($sformatf("n3 rr%0d data", k),  32'(out_data3),  32'(chan_data3[e]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
